// File: rtl/imem_responder.sv
// imem_responder: memory end of the core's instruction-fetch interface.
// Accepts byte-address fetches over valid/ready and returns the 32-bit word
// through a single response register. A side load port writes program words,
// and it keeps working while rst is asserted.
// Optional feature: define IMEM_FETCH_CNT_EN to enable the saturating
// accepted-fetch counter on fetch_count; otherwise fetch_count is tied to 0.
module imem_responder #(
  parameter int          ADDR_W      = 8,
  parameter int          DEPTH       = 64,
  parameter logic [31:0] RESET_INSTR = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_instr,
  output logic                     rsp_err,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [31:0]              load_data,
  output logic [15:0]              fetch_count
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-3:0] req_word;
  logic [AW-1:0]     rd_idx;
  logic              req_err;
  logic              load_ok;
  logic              bypass;
  logic [31:0]       rd_data;
  logic              accept;

  // Decode the fetch address and pick the read word, forwarding a same-edge load.
  always_comb begin
    req_word  = req_addr[ADDR_W-1:2];
    rd_idx    = AW'(req_word);
    req_err   = (req_addr[1:0] != 2'b00) || (32'(req_word) >= 32'(DEPTH));
    load_ok   = load_en && (32'(load_addr) < 32'(DEPTH));
    bypass    = load_ok && (load_addr == rd_idx);
    rd_data   = bypass ? load_data : mem[rd_idx];
    req_ready = !rst && (!rsp_valid || rsp_ready);
    accept    = req_valid && req_ready;
  end

  // Program storage: never reset, so a preload done under rst survives it.
  always_ff @(posedge clk) begin
    if (load_ok) begin
      mem[load_addr] <= load_data;
    end
  end

  // Response register: loads on accept, holds until consumed, then drops valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_instr <= RESET_INSTR;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_err   <= req_err;
      rsp_instr <= req_err ? RESET_INSTR : rd_data;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef IMEM_FETCH_CNT_EN
  logic [15:0] cnt_q;

  // Accepted-fetch counter, error fetches included; sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 16'h0;
    end else if (accept && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'h1;
    end
  end

  assign fetch_count = cnt_q;
`else
  assign fetch_count = 16'h0;
`endif

endmodule
